exe_stage: RTL and testbench

//  Parametrised RISC-V execute stage with a registered output, placed between decode and mem.

---
 rtl/exe_stage.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// exe_stage: RISC-V execute stage between decode and mem.
// Single-cycle ALU, branch and load/store address ops land in a registered
// output stage one cycle after acceptance. With EXE_MULDIV_EN defined, an
// iterative radix-2 mul/div unit runs optypes 25-30 in MD_CYCLES+1 cycles.
// Without it, md_busy is tied low and 25-30 retire as NOP.
// Immediate optypes: 10 ADDI, 11 ANDI, 12 ORI, 13 XORI, 14 SLLI, 15 SRAI.
// Ports:
//   clk, rst (sync, active high), clr (flush held/in-flight op)
//   in_valid/in_ready, optype, pc, data1, data2, immediate, offset  : decode side
//   out_valid/out_ready, write_reg, load_en, store_en, addr, data,
//   jmp_en, jmp_addr, res                                          : mem side
//   md_busy : mul/div unit iterating or finishing
module exe_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned OPW       = 5,
    parameter int unsigned MD_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  optype,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] offset,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            write_reg,
    output logic            load_en,
    output logic            store_en,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] data,
    output logic            jmp_en,
    output logic [XLEN-1:0] jmp_addr,
    output logic [XLEN-1:0] res,
    output logic            md_busy
);
    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(6);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(7);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(9);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(10);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(11);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(12);
    localparam logic [OPW-1:0] OP_XORI = OPW'(13);
    localparam logic [OPW-1:0] OP_SLLI = OPW'(14);
    localparam logic [OPW-1:0] OP_SRAI = OPW'(15);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(16);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(17);
    localparam logic [OPW-1:0] OP_BLT  = OPW'(18);
    localparam logic [OPW-1:0] OP_BGE  = OPW'(19);
    localparam logic [OPW-1:0] OP_BLTU = OPW'(20);
    localparam logic [OPW-1:0] OP_BGEU = OPW'(21);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(22);
    localparam logic [OPW-1:0] OP_LW   = OPW'(23);
    localparam logic [OPW-1:0] OP_SW   = OPW'(24);

    logic            w_accept;
    logic            w_is_md;
    logic            w_imm_op;
    logic [XLEN-1:0] w_src2;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_addr;
    logic [XLEN-1:0] w_res;
    logic            w_wr;
    logic            w_ld;
    logic            w_st;
    logic            w_jmp;

    assign w_imm_op = (optype >= OP_ADDI) && (optype <= OP_SRAI);
    assign w_addr   = data1 + immediate;
    assign w_accept = in_valid && in_ready && !clr;

    // Single-cycle datapath: result and side-effect flags for the presented op
    always_comb begin
        w_src2  = w_imm_op ? immediate : data2;
        w_shamt = w_src2[SHW-1:0];
        w_res   = '0;
        w_wr    = 1'b0;
        w_ld    = 1'b0;
        w_st    = 1'b0;
        w_jmp   = 1'b0;
        case (optype)
            OP_ADD, OP_ADDI: begin w_wr = 1'b1; w_res = data1 + w_src2; end
            OP_SUB:          begin w_wr = 1'b1; w_res = data1 - w_src2; end
            OP_AND, OP_ANDI: begin w_wr = 1'b1; w_res = data1 & w_src2; end
            OP_OR,  OP_ORI:  begin w_wr = 1'b1; w_res = data1 | w_src2; end
            OP_XOR, OP_XORI: begin w_wr = 1'b1; w_res = data1 ^ w_src2; end
            OP_SLL, OP_SLLI: begin w_wr = 1'b1; w_res = data1 << w_shamt; end
            OP_SRL:          begin w_wr = 1'b1; w_res = data1 >> w_shamt; end
            OP_SRA, OP_SRAI: begin w_wr = 1'b1; w_res = XLEN'($signed(data1) >>> w_shamt); end
            OP_SLT:          begin w_wr = 1'b1; w_res = XLEN'($signed(data1) < $signed(w_src2)); end
            OP_SLTU:         begin w_wr = 1'b1; w_res = XLEN'(data1 < w_src2); end
            OP_BEQ:          w_jmp = (data1 == data2);
            OP_BNE:          w_jmp = (data1 != data2);
            OP_BLT:          w_jmp = ($signed(data1) <  $signed(data2));
            OP_BGE:          w_jmp = ($signed(data1) >= $signed(data2));
            OP_BLTU:         w_jmp = (data1 <  data2);
            OP_BGEU:         w_jmp = (data1 >= data2);
            OP_JAL:          begin w_wr = 1'b1; w_jmp = 1'b1; w_res = pc + XLEN'(4); end
            OP_LW:           begin w_wr = 1'b1; w_ld = 1'b1; w_res = w_addr; end
            OP_SW:           w_st = 1'b1;
            default:         ;
        endcase
    end

`ifdef EXE_MULDIV_EN
    localparam int unsigned CW = $clog2(MD_CYCLES + 1);

    localparam logic [OPW-1:0] OP_MUL   = OPW'(25);
    localparam logic [OPW-1:0] OP_MULHU = OPW'(26);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(27);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(28);
    localparam logic [OPW-1:0] OP_REM   = OPW'(29);
    localparam logic [OPW-1:0] OP_REMU  = OPW'(30);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [OPW-1:0]  r_op;
    logic            r_is_mul;
    logic            r_div0;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;

    logic            w_md_sgn;
    logic            w_md_mul;
    logic            w_md_fin;
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_sh;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_sub;
    logic [XLEN-1:0] w_step_hi;
    logic [XLEN-1:0] w_step_lo;
    logic [XLEN-1:0] w_md_res;

    assign w_is_md  = (optype >= OP_MUL) && (optype <= OP_REMU);
    assign w_md_sgn = (optype == OP_DIV) || (optype == OP_REM);
    assign w_md_mul = (optype == OP_MUL) || (optype == OP_MULHU);
    // Output regs take the final step result directly, so DONE already shows it
    assign w_md_fin = (r_state == ST_CALC) && (r_cnt == CW'(MD_CYCLES - 1));
    assign in_ready = (r_state == ST_IDLE) && (!out_valid || out_ready);
    assign md_busy  = (r_state != ST_IDLE);

    // One radix-2 iteration: shift-add multiply or restoring divide on {r_hi, r_lo}
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_div_sh  = {r_hi, r_lo[XLEN-1]};
        // Partial remainder stays below the divisor, so the difference fits XLEN bits
        w_div_ge  = w_div_sh[XLEN] || (w_div_sh[XLEN-1:0] >= r_b);
        w_div_sub = w_div_sh[XLEN-1:0] - r_b;
        if (r_is_mul) begin
            w_step_hi = w_mul_sum[XLEN:1];
            w_step_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end else if (w_div_ge) begin
            w_step_hi = w_div_sub;
            w_step_lo = {r_lo[XLEN-2:0], 1'b1};
        end else begin
            w_step_hi = w_div_sh[XLEN-1:0];
            w_step_lo = {r_lo[XLEN-2:0], 1'b0};
        end
    end

    // Final result select with sign fix-up and divide-by-zero override
    always_comb begin
        w_md_res = '0;
        case (r_op)
            OP_MUL:          w_md_res = w_step_lo;
            OP_MULHU:        w_md_res = w_step_hi;
            OP_DIV, OP_DIVU: w_md_res = r_div0 ? '1 : (r_neg_q ? -w_step_lo : w_step_lo);
            default:         w_md_res = r_div0 ? r_a : (r_neg_r ? -w_step_hi : w_step_hi);
        endcase
    end

    // Mul/div FSM and iteration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_is_mul <= 1'b0;
            r_div0   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_md) begin
                        r_state  <= ST_CALC;
                        r_cnt    <= '0;
                        r_op     <= optype;
                        r_is_mul <= w_md_mul;
                        r_div0   <= (data2 == '0);
                        r_neg_q  <= w_md_sgn && (data1[XLEN-1] ^ data2[XLEN-1]);
                        r_neg_r  <= w_md_sgn && data1[XLEN-1];
                        r_a      <= data1;
                        r_hi     <= '0;
                        r_lo     <= (w_md_sgn && data1[XLEN-1]) ? -data1 : data1;
                        r_b      <= (w_md_sgn && data2[XLEN-1]) ? -data2 : data2;
                    end
                end
                ST_CALC: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_md_fin) r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (MD_CYCLES == 0);
    assign w_is_md      = 1'b0;
    assign in_ready     = !out_valid || out_ready;
    assign md_busy      = 1'b0;
`endif

    // Output register: flush > new single-cycle op > mul/div finish > drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            write_reg <= 1'b0;
            load_en   <= 1'b0;
            store_en  <= 1'b0;
            jmp_en    <= 1'b0;
            addr      <= '0;
            data      <= '0;
            jmp_addr  <= '0;
            res       <= '0;
        end else if (clr) begin
            out_valid <= 1'b0;
            write_reg <= 1'b0;
            load_en   <= 1'b0;
            store_en  <= 1'b0;
            jmp_en    <= 1'b0;
        end else if (w_accept && !w_is_md) begin
            out_valid <= 1'b1;
            write_reg <= w_wr;
            load_en   <= w_ld;
            store_en  <= w_st;
            jmp_en    <= w_jmp;
            addr      <= w_addr;
            data      <= data2;
            jmp_addr  <= pc + offset;
            res       <= w_res;
        end
`ifdef EXE_MULDIV_EN
        else if (w_md_fin) begin
            out_valid <= 1'b1;
            write_reg <= 1'b1;
            load_en   <= 1'b0;
            store_en  <= 1'b0;
            jmp_en    <= 1'b0;
            res       <= w_md_res;
        end
`endif
        else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            write_reg <= 1'b0;
            load_en   <= 1'b0;
            store_en  <= 1'b0;
            jmp_en    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Testbench for exe_stage: directed cases followed by random ops compared
// against an arithmetic reference model. Mul/div cases are built only when
// EXE_MULDIV_EN is defined, matching the DUT configuration.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  optype;
    logic [31:0] pc;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] immediate;
    logic [31:0] offset;
    logic        out_valid;
    logic        out_ready;
    logic        write_reg;
    logic        load_en;
    logic        store_en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        jmp_en;
    logic [31:0] jmp_addr;
    logic [31:0] res;
    logic        md_busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        wr;
        logic        ld;
        logic        st;
        logic        jmp;
        logic [31:0] res;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] jaddr;
    } exp_t;

    exe_stage #(.XLEN(32), .OPW(5), .MD_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .optype(optype),
        .pc(pc), .data1(data1), .data2(data2), .immediate(immediate), .offset(offset),
        .out_valid(out_valid), .out_ready(out_ready),
        .write_reg(write_reg), .load_en(load_en), .store_en(store_en),
        .addr(addr), .data(data), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
        .res(res), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic is_md(input logic [4:0] op);
`ifdef EXE_MULDIV_EN
        return (op >= 5'd25) && (op <= 5'd30);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model straight from the instruction table
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] p, a, d2, im, of);
        exp_t        e;
        logic [31:0] b;
        int unsigned sh;
        logic [63:0] prod;
        e    = '0;
        b    = (op >= 5'd10 && op <= 5'd15) ? im : d2;
        sh   = int'(b[4:0]);
        prod = {32'h0, a} * {32'h0, d2};
        case (op)
            5'd0, 5'd10:  begin e.wr = 1'b1; e.res = a + b; end
            5'd1:         begin e.wr = 1'b1; e.res = a - b; end
            5'd2, 5'd11:  begin e.wr = 1'b1; e.res = a & b; end
            5'd3, 5'd12:  begin e.wr = 1'b1; e.res = a | b; end
            5'd4, 5'd13:  begin e.wr = 1'b1; e.res = a ^ b; end
            5'd5, 5'd14:  begin e.wr = 1'b1; e.res = a << sh; end
            5'd6:         begin e.wr = 1'b1; e.res = a >> sh; end
            5'd7, 5'd15:  begin
                e.wr  = 1'b1;
                e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            end
            5'd8:  begin e.wr = 1'b1; e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
            5'd9:  begin e.wr = 1'b1; e.res = (a < b) ? 32'd1 : 32'd0; end
            5'd16: e.jmp = (a == d2);
            5'd17: e.jmp = (a != d2);
            5'd18: e.jmp = (int'(a) <  int'(d2));
            5'd19: e.jmp = (int'(a) >= int'(d2));
            5'd20: e.jmp = (a <  d2);
            5'd21: e.jmp = (a >= d2);
            5'd22: begin e.wr = 1'b1; e.jmp = 1'b1; e.res = p + 32'd4; end
            5'd23: begin e.wr = 1'b1; e.ld = 1'b1; e.addr = a + im; e.res = a + im; end
            5'd24: begin e.st = 1'b1; e.addr = a + im; e.data = d2; end
`ifdef EXE_MULDIV_EN
            5'd25: begin e.wr = 1'b1; e.res = prod[31:0]; end
            5'd26: begin e.wr = 1'b1; e.res = prod[63:32]; end
            5'd27: begin
                e.wr = 1'b1;
                if (d2 == 0) e.res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) e.res = a;
                else e.res = 32'(int'(a) / int'(d2));
            end
            5'd28: begin e.wr = 1'b1; e.res = (d2 == 0) ? 32'hFFFF_FFFF : a / d2; end
            5'd29: begin
                e.wr = 1'b1;
                if (d2 == 0) e.res = a;
                else if (a == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) e.res = 32'h0;
                else e.res = 32'(int'(a) % int'(d2));
            end
            5'd30: begin e.wr = 1'b1; e.res = (d2 == 0) ? a : a % d2; end
`endif
            default: ;
        endcase
        e.jaddr = p + of;
        return e;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] p, a, b, im, of);
        optype = op; pc = p; data1 = a; data2 = b; immediate = im; offset = of;
        in_valid = 1'b1;
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge
    task automatic issue(input logic [4:0] op, input logic [31:0] p, a, b, im, of);
        int n;
        drive(op, p, a, b, im, of);
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) check1("accept_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    endtask

    task automatic check_out(input exp_t e);
        check1("out_valid", out_valid, 1'b1);
        check1("write_reg", write_reg, e.wr);
        check1("load_en",   load_en,   e.ld);
        check1("store_en",  store_en,  e.st);
        check1("jmp_en",    jmp_en,    e.jmp);
        if (e.wr)         check("res", res, e.res);
        if (e.ld || e.st) check("addr", addr, e.addr);
        if (e.st)         check("data", data, e.data);
        if (e.jmp)        check("jmp_addr", jmp_addr, e.jaddr);
    endtask

    initial begin
        exp_t        e;
        int          n;
        logic        seen;
        logic [4:0]  op;
        logic [31:0] p, a, b, im, of;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(5'd31, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_in_ready",  in_ready,  1'b1);
        check1("rst_md_busy",   md_busy,   1'b0);
        check1("rst_jmp_en",    jmp_en,    1'b0);
        check1("rst_write_reg", write_reg, 1'b0);
        check("rst_res", res, 32'h0);

        issue(5'd0, 32'h0, 32'd5, 32'd7, 32'h0, 32'h0);
        check1("add_valid", out_valid, 1'b1);
        check1("add_wr", write_reg, 1'b1);
        check("add_res", res, 32'd12);

        issue(5'd16, 32'h100, 32'd3, 32'd3, 32'h0, 32'h20);
        check1("beq_jmp", jmp_en, 1'b1);
        check("beq_addr", jmp_addr, 32'h120);
        check1("beq_wr", write_reg, 1'b0);

        issue(5'd17, 32'h100, 32'd3, 32'd3, 32'h0, 32'h20);
        check1("bne_valid", out_valid, 1'b1);
        check1("bne_jmp", jmp_en, 1'b0);
        check1("bne_wr", write_reg, 1'b0);

        issue(5'd22, 32'h200, 32'h0, 32'h0, 32'h0, 32'h40);
        check("jal_res", res, 32'h204);
        check("jal_addr", jmp_addr, 32'h240);
        check1("jal_jmp", jmp_en, 1'b1);

        issue(5'd23, 32'h0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 32'h0);
        check1("lw_ld", load_en, 1'b1);
        check("lw_addr", addr, 32'hFFC);

        issue(5'd24, 32'h0, 32'h1000, 32'hAB, 32'hFFFF_FFFC, 32'h0);
        check1("sw_st", store_en, 1'b1);
        check("sw_data", data, 32'hAB);
        check1("sw_wr", write_reg, 1'b0);

        // Jump pulse ends after its single handshake
        @(posedge clk); #1;
        check1("drain_valid", out_valid, 1'b0);
        check1("drain_jmp", jmp_en, 1'b0);

        // Backpressure: output held, pending op waits, then both move in one edge
        out_ready = 1'b0;
        issue(5'd0, 32'h0, 32'd5, 32'd7, 32'h0, 32'h0);
        drive(5'd1, 32'h0, 32'd20, 32'd3, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check1("stall_valid", out_valid, 1'b1);
            check("stall_res", res, 32'd12);
            check1("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check1("unstall_valid", out_valid, 1'b1);
        check("unstall_res", res, 32'd17);

        // Flush drops the held result and blocks the op offered alongside it
        issue(5'd0, 32'h0, 32'd1, 32'd2, 32'h0, 32'h0);
        drive(5'd0, 32'h0, 32'd9, 32'd9, 32'h0, 32'h0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0;
        check1("clr_valid", out_valid, 1'b0);
        check1("clr_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check1("clr_no_accept", out_valid, 1'b0);

`ifdef EXE_MULDIV_EN
        issue(5'd27, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
        check1("div_busy", md_busy, 1'b1);
        wait_out(n);
        check("div_latency", 32'(n + 1), 32'd33);
        check("div_res", res, 32'hFFFF_FFFD);
        issue(5'd29, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
        wait_out(n);
        check("rem_res", res, 32'hFFFF_FFFF);
        issue(5'd28, 32'h0, 32'h1234, 32'd0, 32'h0, 32'h0);
        wait_out(n);
        check("divu0_res", res, 32'hFFFF_FFFF);
        issue(5'd25, 32'h0, 32'hFFFF, 32'h10001, 32'h0, 32'h0);
        wait_out(n);
        check("mul_res", res, 32'hFFFF_FFFF);
        issue(5'd26, 32'h0, 32'hFFFF, 32'h10001, 32'h0, 32'h0);
        wait_out(n);
        check("mulhu_res", res, 32'h0);

        issue(5'd27, 32'h0, 32'd100, 32'd7, 32'h0, 32'h0);
        repeat (9) begin @(posedge clk); #1; end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check1("mdclr_busy", md_busy, 1'b0);
        check1("mdclr_valid", out_valid, 1'b0);
        check1("mdclr_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; seen = seen | out_valid; end
        check1("mdclr_no_result", seen, 1'b0);
`else
        issue(5'd25, 32'h0, 32'hFFFF, 32'h10001, 32'h0, 32'h0);
        check1("md_off_valid", out_valid, 1'b1);
        check1("md_off_wr", write_reg, 1'b0);
        check1("md_off_busy", md_busy, 1'b0);
`endif

        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 31));
            p  = $urandom() & 32'hFFFF_FFFC;
            a  = rnd_val();
            b  = rnd_val();
            im = rnd_val();
            of = rnd_val();
            issue(op, p, a, b, im, of);
            if (is_md(op)) begin
                wait_out(n);
                check("rnd_md_latency", 32'(n + 1), 32'd33);
            end
            e = model(op, p, a, b, im, of);
            check_out(e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
